data_mem_be: RTL

DATA_MEM_BE -- requirements
Module: data_mem_be

---
 rtl/data_mem_be.sv | 137 +++++++++++++
 1 files changed

// File: rtl/data_mem_be.sv
// data_mem_be: byte-enabled 32-bit data memory with a one-cycle response pipeline
// and an optional post-reset zeroing sweep of every word.
module data_mem_be #(
   parameter int unsigned DEPTH          = 64,
   parameter bit          CLEAR_ON_RESET = 1'b1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_we,
   input  logic [1:0]  req_size,
   input  logic        req_unsigned,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        resp_valid,
   output logic [31:0] resp_rdata,
   output logic        resp_err,
   output logic        init_done
);

   localparam int unsigned AW = $clog2(DEPTH);

   typedef enum logic {INIT, RUN} state_t;

   state_t        r_state;
   logic [AW-1:0] r_init_cnt;
   logic [31:0]   r_mem [DEPTH];
   logic          r_resp_valid;
   logic          r_resp_err;
   logic [31:0]   r_resp_rdata;

   logic          w_accept;
   logic          w_misaligned;
   logic          w_oor;
   logic          w_err;
   logic [AW-1:0] w_idx;
   logic [3:0]    w_be;
   logic [31:0]   w_wlanes;
   logic [31:0]   w_rword;
   logic [31:0]   w_merged;
   logic [7:0]    w_byte;
   logic [15:0]   w_half;
   logic [31:0]   w_load;

   // Outputs are forced low combinationally while rst is high, which also
   // suppresses a response that would otherwise appear during a reset cycle.
   assign req_ready  = (r_state == RUN) && !rst;
   assign init_done  = (r_state == RUN) && !rst;
   assign resp_valid = r_resp_valid && !rst;
   assign resp_err   = r_resp_err && !rst;
   assign resp_rdata = rst ? '0 : r_resp_rdata;

   assign w_accept = req_valid && req_ready;
   assign w_idx    = req_addr[AW+1:2];
   assign w_oor    = |req_addr[31:AW+2];
   assign w_rword  = r_mem[w_idx];

   always_comb begin
      w_misaligned = 1'b0;
      w_be         = '0;
      w_wlanes     = req_wdata;
      case (req_size)
         2'b00: begin
            w_be     = 4'b0001 << req_addr[1:0];
            w_wlanes = {4{req_wdata[7:0]}};
         end
         2'b01: begin
            w_misaligned = req_addr[0];
            w_be         = req_addr[1] ? 4'b1100 : 4'b0011;
            w_wlanes     = {2{req_wdata[15:0]}};
         end
         2'b10: begin
            w_misaligned = |req_addr[1:0];
            w_be         = 4'b1111;
         end
         default: ;
      endcase
      w_err = (req_size == 2'b11) || w_misaligned || w_oor;
   end

   always_comb begin
      w_merged = w_rword;
      for (int unsigned l = 0; l < 4; l++) begin
         if (w_be[l]) w_merged[8*l +: 8] = w_wlanes[8*l +: 8];
      end
   end

   always_comb begin
      case (req_addr[1:0])
         2'b00:   w_byte = w_rword[7:0];
         2'b01:   w_byte = w_rword[15:8];
         2'b10:   w_byte = w_rword[23:16];
         default: w_byte = w_rword[31:24];
      endcase
      w_half = req_addr[1] ? w_rword[31:16] : w_rword[15:0];
      case (req_size)
         2'b00:   w_load = {{24{!req_unsigned && w_byte[7]}}, w_byte};
         2'b01:   w_load = {{16{!req_unsigned && w_half[15]}}, w_half};
         default: w_load = w_rword;
      endcase
   end

   // Storage is never reset so contents survive reset when the sweep is disabled.
   always_ff @(posedge clk) begin
      if (!rst) begin
         if (r_state == INIT) begin
            if (CLEAR_ON_RESET) r_mem[r_init_cnt] <= '0;
         end else if (w_accept && req_we && !w_err) begin
            r_mem[w_idx] <= w_merged;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state      <= INIT;
         r_init_cnt   <= '0;
         r_resp_valid <= 1'b0;
         r_resp_err   <= 1'b0;
         r_resp_rdata <= '0;
      end else begin
         r_resp_valid <= w_accept;
         r_resp_err   <= w_accept && w_err;
         r_resp_rdata <= (w_accept && !req_we && !w_err) ? w_load : '0;
         case (r_state)
            INIT: begin
               r_init_cnt <= r_init_cnt + 1'b1;
               if (!CLEAR_ON_RESET || (r_init_cnt == AW'(DEPTH - 1))) r_state <= RUN;
            end
            RUN:     r_state <= RUN;
            default: r_state <= INIT;
         endcase
      end
   end

endmodule
